// File: rtl/neb_uart_tx_if.sv
// ---------------------------------------------------------------------------
// neb_uart_tx_if
// Byte handshake between a producer (the datapath) and the UART transmitter.
//
// Handshake: the producer drives in_data and raises in_valid; the transmitter
// raises in_ready when it can take a byte. A byte moves only on a rising clock
// edge where in_valid && in_ready are both high. in_data is sampled only on that
// edge. The producer may drop or change in_valid/in_data at any time while
// in_ready is low; nothing is queued.
//
// Signals:
//   in_data  [7:0]  byte to transmit            (producer -> transmitter)
//   in_valid        producer has a byte          (producer -> transmitter)
//   in_ready        transmitter can accept       (transmitter -> producer)
// ---------------------------------------------------------------------------
interface neb_uart_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/neb_uart_tx.sv
// ---------------------------------------------------------------------------
// neb_uart_tx
// UART transmitter: accepts one byte over a valid/ready handshake and sends it
// LSB first as start bit, 8 data bits, optional parity bit, 1 or 2 stop bits.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous reset, active-high
//   in_bus     slave side of neb_uart_tx_if (in_data, in_valid, in_ready)
//   tx         serial line, idle high, registered
//   busy       high while a frame is in progress, registered
//   done       one-cycle pulse in the cycle after the last stop cycle
//   state_dbg  current FSM state, for observation only
// ---------------------------------------------------------------------------
module neb_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               rst,
  neb_uart_tx_if.slave       in_bus,
  output logic               tx,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_dbg
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  logic [2:0]    state;
  logic [CW-1:0] cyc;
  // Indexes data bits in DATA and counts stop bits in STOP.
  logic [2:0]    bit_idx;
  // Holds the accepted byte unchanged for the whole frame so parity can be
  // computed from it at the end of the data bits.
  logic [7:0]    data_q;
  logic          parity_bit;

  assign parity_bit      = (PARITY_ODD != 0) ? ~^data_q : ^data_q;
  assign in_bus.in_ready = (state == ST_IDLE) && !rst;
  assign state_dbg       = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      cyc     <= '0;
      bit_idx <= '0;
      data_q  <= '0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        // in_ready is high whenever we are here out of reset.
        if (in_bus.in_valid) begin
          data_q  <= in_bus.in_data;
          state   <= ST_START;
          tx      <= 1'b0;
          busy    <= 1'b1;
          cyc     <= '0;
          bit_idx <= '0;
        end
      end else if (cyc != CYC_LAST) begin
        cyc <= cyc + 1'b1;
      end else begin
        // Bit boundary: the only place tx is allowed to change.
        cyc <= '0;
        case (state)
          ST_START: begin
            state   <= ST_DATA;
            tx      <= data_q[0];
            bit_idx <= '0;
          end
          ST_DATA: begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                state <= ST_PARITY;
                tx    <= parity_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= data_q[bit_idx + 3'd1];
            end
          end
          ST_PARITY: begin
            state   <= ST_STOP;
            tx      <= 1'b1;
            bit_idx <= '0;
          end
          ST_STOP: begin
            if (bit_idx == STOP_LAST) begin
              state   <= ST_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            bit_idx <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_neb_uart_tx
// Four transmitters with CLKS_PER_BIT=4:
//   0: 8N1   1: 8E1   2: 8O1   3: 8N2
// Directed frames with hand-computed bit patterns.
// ---------------------------------------------------------------------------
module tb_neb_uart_tx;

  localparam int C = 4;

  logic       clk;
  logic       rst;
  logic [7:0] drv_data [4];
  logic [3:0] drv_valid;
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;
  logic [3:0] ready_w;

  int n_vec;
  int n_err;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  for (genvar g = 0; g < 4; g++) begin : g_dut
    neb_uart_tx_if bus ();
    logic [2:0] st_dbg;

    assign bus.in_data  = drv_data[g];
    assign bus.in_valid = drv_valid[g];
    assign ready_w[g]   = bus.in_ready;

    neb_uart_tx #(
      .CLKS_PER_BIT (C),
      .PARITY_EN    ((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD   ((g == 2) ? 1 : 0),
      .STOP_BITS    ((g == 3) ? 2 : 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_bus    (bus.slave),
      .tx        (tx_w[g]),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .state_dbg (st_dbg)
    );
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  // Present a byte, check it is acceptable, and return at the first frame cycle.
  task automatic launch(input int idx, input logic [7:0] data, input bit hold);
    @(negedge clk);
    drv_data[idx]  = data;
    drv_valid[idx] = 1'b1;
    check($sformatf("ready_pre%0d", idx), 32'(ready_w[idx]), 32'd1);
    @(negedge clk);
    if (!hold) drv_valid[idx] = 1'b0;
  endtask

  // Walk one frame from its first cycle, checking every cycle, and finish at
  // the done cycle. pbit is the hand-computed parity bit.
  task automatic expect_frame(input int idx, input logic [7:0] data, input bit pe,
                              input logic pbit, input int sb, input bit noise);
    int   len;
    int   slot;
    logic exp_tx;
    len = (1 + 8 + int'(pe) + sb) * C;
    for (int k = 0; k < len; k++) begin
      slot = k / C;
      if (slot == 0)             exp_tx = 1'b0;
      else if (slot <= 8)        exp_tx = data[slot-1];
      else if (pe && slot == 9)  exp_tx = pbit;
      else                       exp_tx = 1'b1;
      check($sformatf("tx%0d_c%0d", idx, k), 32'(tx_w[idx]), 32'(exp_tx));
      check($sformatf("busy%0d_c%0d", idx, k), 32'(busy_w[idx]), 32'd1);
      check($sformatf("ready%0d_c%0d", idx, k), 32'(ready_w[idx]), 32'd0);
      check($sformatf("done%0d_c%0d", idx, k), 32'(done_w[idx]), 32'd0);
      if (noise) begin
        drv_valid[idx] = 1'($urandom_range(0, 1));
        drv_data[idx]  = 8'hFF;
      end
      @(negedge clk);
    end
    check($sformatf("done%0d_end", idx), 32'(done_w[idx]), 32'd1);
    check($sformatf("busy%0d_end", idx), 32'(busy_w[idx]), 32'd0);
    check($sformatf("tx%0d_end", idx), 32'(tx_w[idx]), 32'd1);
    check($sformatf("ready%0d_end", idx), 32'(ready_w[idx]), 32'd1);
    if (noise) drv_valid[idx] = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    drv_valid = '0;
    for (int i = 0; i < 4; i++) drv_data[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_tx%0d", i), 32'(tx_w[i]), 32'd1);
      check($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 32'd0);
      check($sformatf("rst_done%0d", i), 32'(done_w[i]), 32'd0);
      check($sformatf("rst_ready%0d", i), 32'(ready_w[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(ready_w), 32'hF);

    // 8N1 0xA5: 40 busy cycles
    launch(0, 8'hA5, 1'b0);
    expect_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b0);

    // 8E1 0x07 -> parity 1; 8O1 0x07 -> parity 0; 44 busy cycles each
    launch(1, 8'h07, 1'b0);
    expect_frame(1, 8'h07, 1'b1, 1'b1, 1, 1'b0);
    launch(2, 8'h07, 1'b0);
    expect_frame(2, 8'h07, 1'b1, 1'b0, 1, 1'b0);

    // 8N2 0x00: 8 stop cycles, 44 busy cycles
    launch(3, 8'h00, 1'b0);
    expect_frame(3, 8'h00, 1'b0, 1'b0, 2, 1'b0);

    // Back-to-back: valid held, second frame starts right after the done cycle
    launch(0, 8'h55, 1'b1);
    drv_data[0] = 8'h3C;
    expect_frame(0, 8'h55, 1'b0, 1'b0, 1, 1'b0);
    @(negedge clk);
    drv_valid[0] = 1'b0;
    expect_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b0);
    @(negedge clk);
    check("b2b_done_once", 32'(done_w[0]), 32'd0);
    check("b2b_idle_busy", 32'(busy_w[0]), 32'd0);

    // Busy interference: in_valid toggles and in_data=0xFF mid-frame
    launch(0, 8'h5A, 1'b0);
    expect_frame(0, 8'h5A, 1'b0, 1'b0, 1, 1'b1);
    @(negedge clk);
    check("noise_idle_busy", 32'(busy_w[0]), 32'd0);
    check("noise_idle_tx", 32'(tx_w[0]), 32'd1);

    // Reset during data bit 3 of 0xA5 (bit 3 = 0)
    launch(0, 8'hA5, 1'b0);
    repeat (16) @(negedge clk);
    check("mid_bit3_tx", 32'(tx_w[0]), 32'd0);
    check("mid_bit3_busy", 32'(busy_w[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", 32'(tx_w[0]), 32'd1);
    check("abort_busy", 32'(busy_w[0]), 32'd0);
    check("abort_done", 32'(done_w[0]), 32'd0);
    check("abort_ready", 32'(ready_w[0]), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("abort_nodone%0d", k), 32'(done_w[0]), 32'd0);
      check($sformatf("abort_idle_tx%0d", k), 32'(tx_w[0]), 32'd1);
    end
    launch(0, 8'hC3, 1'b0);
    expect_frame(0, 8'hC3, 1'b0, 1'b0, 1, 1'b0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
